// File: rtl/multicycle_control_unit_pkg.sv
// Shared constants for the multi-cycle CPU control path: opcodes, ALU codes,
// operand/PC mux codes and the control FSM state encoding.
package multicycle_control_unit_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;

  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h6;
  localparam logic [3:0] OP_SW   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_BNE  = 4'h9;
  localparam logic [3:0] OP_BLT  = 4'hA;
  localparam logic [3:0] OP_J    = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_TWO    = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_WB_R     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_I     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12,
    S_ILLEGAL  = 4'd13
  } state_e;

  function automatic logic is_rtype(input logic [3:0] op);
    return op <= ALU_XOR;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Branch resolution: decides whether a conditional branch is taken from the
// latched opcode and the ALU flags of the compare (A - B).
module branch_cond_eval
  import multicycle_control_unit_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       negative,
  output logic       take
);

  always_comb begin
    take = 1'b0;
    case (opcode)
      OP_BEQ:  take = zero;
      OP_BNE:  take = ~zero;
      OP_BLT:  take = negative;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Main control FSM of the 16-bit multi-cycle CPU: sequences fetch/decode/execute/
// memory/writeback and drives the ALU opcode, mux selects and write enables.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int ALUOP_W = 4,
  parameter int STATE_W = 4
) (
  input  logic               input_CLK,
  input  logic               input_Reset,
  input  logic [3:0]         input_Opcode,
  input  logic               input_Zero,
  input  logic               input_Negative,
  input  logic               input_MemReady,
  output logic [ALUOP_W-1:0] output_ALUOp,
  output logic               output_ALUSrcA,
  output logic [1:0]         output_ALUSrcB,
  output logic [1:0]         output_PCSource,
  output logic               output_PCWrite,
  output logic               output_IorD,
  output logic               output_MemRead,
  output logic               output_MemWrite,
  output logic               output_IRWrite,
  output logic               output_RegWrite,
  output logic               output_RegDst,
  output logic               output_MemToReg,
  output logic               output_Halted,
  output logic [STATE_W-1:0] output_State
);

  state_e     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic       branch_take;

  logic [3:0] alu_op;
  logic       src_a, pc_write, iord, mem_read, mem_write, ir_write;
  logic       reg_write, reg_dst, mem_to_reg, halted;
  logic [1:0] src_b, pc_source;

  // The opcode is latched at DECODE so no output depends combinationally on IR.
  branch_cond_eval u_branch_cond_eval (
    .opcode   (op_q),
    .zero     (input_Zero),
    .negative (input_Negative),
    .take     (branch_take)
  );

  always_ff @(posedge input_CLK) begin
    if (input_Reset) begin
      state_q <= S_FETCH;
      op_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    alu_op     = ALU_ADD;
    src_a      = 1'b0;
    src_b      = SRCB_REGB;
    pc_source  = PCSRC_ALU;
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    halted     = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        src_b    = SRCB_TWO;
        ir_write = input_MemReady;
        pc_write = input_MemReady;
        if (input_MemReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        src_b = SRCB_IMM_SH;
        op_d  = input_Opcode;
        if (is_rtype(input_Opcode)) state_d = S_EXEC_R;
        else begin
          case (input_Opcode)
            OP_ADDI:                state_d = S_EXEC_I;
            OP_LW, OP_SW:           state_d = S_MEM_ADDR;
            OP_BEQ, OP_BNE, OP_BLT: state_d = S_BRANCH;
            OP_J:                   state_d = S_JUMP;
            OP_HALT:                state_d = S_HALT;
            default:                state_d = S_ILLEGAL;
          endcase
        end
      end
      S_EXEC_R: begin
        src_a   = 1'b1;
        alu_op  = op_q;
        state_d = S_WB_R;
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXEC_I: begin
        src_a   = 1'b1;
        src_b   = SRCB_IMM;
        state_d = S_WB_I;
      end
      S_WB_I: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEM_ADDR: begin
        src_a   = 1'b1;
        src_b   = SRCB_IMM;
        state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (input_MemReady) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (input_MemReady) state_d = S_FETCH;
      end
      S_BRANCH: begin
        src_a     = 1'b1;
        alu_op    = ALU_SUB;
        pc_source = PCSRC_ALUOUT;
        pc_write  = branch_take;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_source = PCSRC_JUMP;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT:    halted = 1'b1;
      S_ILLEGAL: halted = 1'b1;
      default: begin
        halted  = 1'b1;
        state_d = S_ILLEGAL;
      end
    endcase

    // Reset silences every enable in the cycle it is asserted.
    if (input_Reset) begin
      alu_op     = ALU_ADD;
      src_a      = 1'b0;
      src_b      = SRCB_REGB;
      pc_source  = PCSRC_ALU;
      pc_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      halted     = 1'b0;
    end
  end

  assign output_ALUOp    = ALUOP_W'(alu_op);
  assign output_ALUSrcA  = src_a;
  assign output_ALUSrcB  = src_b;
  assign output_PCSource = pc_source;
  assign output_PCWrite  = pc_write;
  assign output_IorD     = iord;
  assign output_MemRead  = mem_read;
  assign output_MemWrite = mem_write;
  assign output_IRWrite  = ir_write;
  assign output_RegWrite = reg_write;
  assign output_RegDst   = reg_dst;
  assign output_MemToReg = mem_to_reg;
  assign output_Halted   = halted;
  assign output_State    = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: builds per-cycle expected control vectors
// from each instruction's phase list, then replays stimulus and compares.
module tb_multicycle_control_unit;
  import multicycle_control_unit_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  logic       zero, negative, mem_ready;
  logic [3:0] alu_op;
  logic       src_a, pc_write, iord, mem_read, mem_write, ir_write;
  logic       reg_write, reg_dst, mem_to_reg, halted;
  logic [1:0] src_b, pc_source;
  logic [3:0] state;
  logic [17:0] got;

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .input_CLK       (clk),
    .input_Reset     (rst),
    .input_Opcode    (opcode),
    .input_Zero      (zero),
    .input_Negative  (negative),
    .input_MemReady  (mem_ready),
    .output_ALUOp    (alu_op),
    .output_ALUSrcA  (src_a),
    .output_ALUSrcB  (src_b),
    .output_PCSource (pc_source),
    .output_PCWrite  (pc_write),
    .output_IorD     (iord),
    .output_MemRead  (mem_read),
    .output_MemWrite (mem_write),
    .output_IRWrite  (ir_write),
    .output_RegWrite (reg_write),
    .output_RegDst   (reg_dst),
    .output_MemToReg (mem_to_reg),
    .output_Halted   (halted),
    .output_State    (state)
  );

  assign got = {alu_op, src_a, src_b, pc_source, pc_write, iord, mem_read,
                mem_write, ir_write, reg_write, reg_dst, mem_to_reg, halted};

  typedef struct packed {
    logic       rst;
    logic       rdy;
    logic [3:0] op;
    logic       z;
    logic       n;
    logic       chk_st;
  } stim_t;

  stim_t       stim_q[$];
  logic [17:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        chk_next = 1'b0;

  task automatic check_eq(input string tag, input int idx, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, idx, obs, exp);
    end
  endtask

  function automatic logic [17:0] mk(input logic [3:0] alu, input logic sa,
      input logic [1:0] sb, input logic [1:0] pcs, input logic pcw, input logic io,
      input logic mr, input logic mw, input logic irw, input logic rw,
      input logic rd, input logic m2r, input logic h);
    return {alu, sa, sb, pcs, pcw, io, mr, mw, irw, rw, rd, m2r, h};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] r4();
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic push(input logic r, input logic rdy, input logic [3:0] op,
                      input logic z, input logic n, input logic [17:0] e);
    stim_q.push_back('{r, rdy, op, z, n, chk_next});
    chk_next = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic add_reset(input int cycles);
    for (int i = 0; i < cycles; i++) push(1'b1, rb(), r4(), rb(), rb(), 18'd0);
    chk_next = 1'b1;
  endtask

  // Fetch phase: opcode is garbage until the IR loads, so drive noise there.
  task automatic add_fetch(input int waits);
    for (int i = 0; i < waits; i++)
      push(1'b0, 1'b0, r4(), rb(), rb(), mk(4'd0, 0, 2'b01, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    push(1'b0, 1'b1, r4(), rb(), rb(), mk(4'd0, 0, 2'b01, 2'b00, 1, 0, 1, 0, 1, 0, 0, 0, 0));
  endtask

  task automatic add_instr(input logic [3:0] op, input int fw, input int mw,
                           input logic z, input logic n);
    logic take;
    add_fetch(fw);
    push(1'b0, rb(), op, rb(), rb(), mk(4'd0, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    if (op <= 4'd4) begin
      push(1'b0, rb(), op, rb(), rb(), mk(op, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      push(1'b0, rb(), op, rb(), rb(), mk(4'd0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    end else begin
      case (op)
        4'h5: begin
          push(1'b0, rb(), op, rb(), rb(), mk(4'd0, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
          push(1'b0, rb(), op, rb(), rb(), mk(4'd0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        end
        4'h6: begin
          push(1'b0, rb(), op, rb(), rb(), mk(4'd0, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
          for (int i = 0; i <= mw; i++)
            push(1'b0, (i == mw), op, rb(), rb(), mk(4'd0, 0, 2'b00, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0, 0));
          push(1'b0, rb(), op, rb(), rb(), mk(4'd0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        end
        4'h7: begin
          push(1'b0, rb(), op, rb(), rb(), mk(4'd0, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
          for (int i = 0; i <= mw; i++)
            push(1'b0, (i == mw), op, rb(), rb(), mk(4'd0, 0, 2'b00, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        end
        4'h8, 4'h9, 4'hA: begin
          take = (op == 4'h8) ? z : (op == 4'h9) ? !z : n;
          push(1'b0, rb(), op, z, n, mk(4'd1, 1, 2'b00, 2'b01, take, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        4'hB:
          push(1'b0, rb(), op, rb(), rb(), mk(4'd0, 0, 2'b00, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        default:
          for (int i = 0; i < 20; i++)
            push(1'b0, rb(), r4(), rb(), rb(), mk(4'd0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      endcase
    end
  endtask

  initial begin
    stim_t       s;
    logic [17:0] e;
    int          idx;

    rst = 1'b1; opcode = 4'd0; zero = 1'b0; negative = 1'b0; mem_ready = 1'b0;

    add_reset(2);
    add_instr(4'h1, 0, 0, 1'b0, 1'b0);
    // Reset asserted for two cycles while the R-type sits in EXEC_R.
    add_fetch(0);
    push(1'b0, rb(), 4'h2, rb(), rb(), mk(4'd0, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_reset(2);
    add_instr(4'h6, 0, 3, 1'b0, 1'b0);
    add_instr(4'h8, 0, 0, 1'b1, 1'b0);
    add_instr(4'h8, 0, 0, 1'b0, 1'b1);
    add_instr(4'hA, 0, 0, 1'b0, 1'b1);
    add_instr(4'h9, 0, 0, 1'b0, 1'b0);
    add_instr(4'h5, 2, 0, 1'b0, 1'b0);
    add_instr(4'h7, 1, 2, 1'b0, 1'b0);
    add_instr(4'hB, 0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 60; k++)
      add_instr(4'($urandom_range(0, 11)), $urandom_range(0, 2), $urandom_range(0, 3), rb(), rb());
    add_instr(4'hD, 0, 0, 1'b0, 1'b0);
    add_reset(1);
    add_instr(4'hF, 1, 0, 1'b0, 1'b0);
    add_reset(1);
    add_instr(4'h0, 0, 0, 1'b0, 1'b0);

    idx = 0;
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(posedge clk);
      #1;
      rst = s.rst; mem_ready = s.rdy; opcode = s.op; zero = s.z; negative = s.n;
      @(negedge clk);
      check_eq("ctl", idx, 32'(got), 32'(e));
      if (s.chk_st) check_eq("state_after_reset", idx, 32'(state), 32'(S_FETCH));
      idx++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
